mips_multicycle_core: RTL

//  Multi-cycle MIPS-I subset core. Controller FSM, datapath and 32x32 register file live in one block.
//  A single unified instruction/data memory port carries a req/ready handshake, so the core tolerates wait states.

---
 rtl/mips_multicycle_core.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/mips_multicycle_core.sv
// Multi-cycle MIPS-I subset core: controller FSM, datapath and 32x32 register file on one shared memory port.
// Defining MIPS_PERF_CNT_EN adds the cycle_cnt / instret_cnt performance counter ports.
module mips_multicycle_core #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          ADDR_WIDTH = 32,
  parameter int          PERF_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [31:0]           mem_wdata,
  input  logic [31:0]           mem_rdata,
  input  logic                  mem_ready,
  output logic [31:0]           pc,
  output logic                  halted
`ifdef MIPS_PERF_CNT_EN
  ,
  output logic [PERF_WIDTH-1:0] cycle_cnt,
  output logic [PERF_WIDTH-1:0] instret_cnt
`endif
);

  localparam logic [5:0] OP_R = 6'h00, OP_LW = 6'h23, OP_SW = 6'h2B, OP_BEQ = 6'h04,
                         OP_ADDI = 6'h08, OP_J = 6'h02;
  localparam logic [5:0] F_ADD = 6'h20, F_SUB = 6'h22, F_AND = 6'h24, F_OR = 6'h25, F_SLT = 6'h2A;

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB, S_MEMWR, S_EXEC,
    S_ALUWB, S_ADDIEX, S_ADDIWB, S_BRANCH, S_JUMP, S_HALT
  } state_t;

  state_t      state, state_next;
  logic [31:0] ir, reg_a, reg_b, alu_out, mdr, br_target;
  logic [31:0] rf [32];
  logic [5:0]  op, funct;
  logic [4:0]  rs, rt, rd;
  logic [31:0] simm, r_result, addr_full;
  logic        r_legal, rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;

  assign op    = ir[31:26];
  assign rs    = ir[25:21];
  assign rt    = ir[20:16];
  assign rd    = ir[15:11];
  assign funct = ir[5:0];
  assign simm  = {{16{ir[15]}}, ir[15:0]};
  assign r_legal = (funct == F_ADD) || (funct == F_SUB) || (funct == F_AND) ||
                   (funct == F_OR) || (funct == F_SLT);

  always_comb begin
    r_result = '0;
    case (funct)
      F_ADD:   r_result = reg_a + reg_b;
      F_SUB:   r_result = reg_a - reg_b;
      F_AND:   r_result = reg_a & reg_b;
      F_OR:    r_result = reg_a | reg_b;
      F_SLT:   r_result = {31'b0, $signed(reg_a) < $signed(reg_b)};
      default: r_result = '0;
    endcase
  end

  // Handshake: mem_req is high only in FETCH/MEMRD/MEMWR and addr/we/wdata come from registers,
  // so they hold steady until the cycle where mem_req & mem_ready completes the access.
  assign mem_req   = reset && (state == S_FETCH || state == S_MEMRD || state == S_MEMWR);
  assign mem_we    = reset && (state == S_MEMWR);
  assign addr_full = (state == S_FETCH) ? pc : alu_out;
  assign mem_addr  = addr_full[ADDR_WIDTH-1:0];
  assign mem_wdata = reg_b;
  assign halted    = (state == S_HALT);

  always_comb begin
    state_next = state;
    rf_we      = 1'b0;
    rf_waddr   = '0;
    rf_wdata   = '0;
    case (state)
      S_FETCH:  if (mem_ready) state_next = S_DECODE;
      S_DECODE: begin
        case (op)
          OP_LW, OP_SW: state_next = S_MEMADR;
          OP_R:         state_next = r_legal ? S_EXEC : S_HALT;
          OP_ADDI:      state_next = S_ADDIEX;
          OP_BEQ:       state_next = S_BRANCH;
          OP_J:         state_next = S_JUMP;
          default:      state_next = S_HALT;
        endcase
      end
      S_MEMADR: state_next = (op == OP_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD:  if (mem_ready) state_next = S_MEMWB;
      S_MEMWB: begin
        rf_we = 1'b1; rf_waddr = rt; rf_wdata = mdr; state_next = S_FETCH;
      end
      S_MEMWR:  if (mem_ready) state_next = S_FETCH;
      S_EXEC:   state_next = S_ALUWB;
      S_ALUWB: begin
        rf_we = 1'b1; rf_waddr = rd; rf_wdata = alu_out; state_next = S_FETCH;
      end
      S_ADDIEX: state_next = S_ADDIWB;
      S_ADDIWB: begin
        rf_we = 1'b1; rf_waddr = rt; rf_wdata = alu_out; state_next = S_FETCH;
      end
      S_BRANCH, S_JUMP: state_next = S_FETCH;
      S_HALT:   state_next = S_HALT;
      default:  state_next = S_FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= S_FETCH;
      pc        <= RESET_PC;
      ir        <= '0;
      reg_a     <= '0;
      reg_b     <= '0;
      alu_out   <= '0;
      mdr       <= '0;
      br_target <= '0;
    end else begin
      state <= state_next;
      case (state)
        S_FETCH: if (mem_ready) begin
          ir <= mem_rdata;
          pc <= pc + 32'd4;
        end
        S_DECODE: begin
          reg_a     <= (rs == 5'd0) ? 32'd0 : rf[rs];
          reg_b     <= (rt == 5'd0) ? 32'd0 : rf[rt];
          br_target <= pc + {simm[29:0], 2'b00};
        end
        S_MEMADR, S_ADDIEX: alu_out <= reg_a + simm;
        S_EXEC:   alu_out <= r_result;
        S_MEMRD:  if (mem_ready) mdr <= mem_rdata;
        S_BRANCH: if (reg_a == reg_b) pc <= br_target;
        S_JUMP:   pc <= {pc[31:28], ir[25:0], 2'b00};
        default:  ;
      endcase
    end
  end

  // Register file is not cleared by reset; writes are blocked while reset is held and for $0.
  always_ff @(posedge clk) begin
    if (reset && rf_we && rf_waddr != 5'd0) rf[rf_waddr] <= rf_wdata;
  end

`ifdef MIPS_PERF_CNT_EN
  logic instret_inc;
  assign instret_inc = (state == S_MEMWB) || (state == S_ALUWB) || (state == S_ADDIWB) ||
                       (state == S_BRANCH) || (state == S_JUMP) || (state == S_MEMWR && mem_ready);

  always_ff @(posedge clk) begin
    if (!reset) begin
      cycle_cnt   <= '0;
      instret_cnt <= '0;
    end else begin
      if (!halted) cycle_cnt <= cycle_cnt + PERF_WIDTH'(1);
      if (instret_inc) instret_cnt <= instret_cnt + PERF_WIDTH'(1);
    end
  end
`endif

endmodule
